mul_wb_queue: RTL and testbench

//  Writeback buffer directly downstream of the fixed-latency multiplier pipeline.

---
 rtl/mul_wb_pkg.sv | 33 +++
 rtl/wb_fifo.sv | 27 ++
 rtl/mul_wb_queue.sv | 136 +++++++++++++
 tb/tb_mul_wb_queue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_wb_pkg.sv
// Shared types and sizes for the multiplier writeback queue.
// Latency: n/a (package only).
// Backpressure: n/a. Width macros get defaults here when the build does not supply them.
`ifndef MUL_LAT
`define MUL_LAT 3
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 2
`endif

package mul_wb_pkg;
  localparam int DEPTH    = 4;               // FIFO entries, power of 2, >= 2
  localparam int LG_DEPTH = $clog2(DEPTH);
  localparam int LAT      = `MUL_LAT;        // go -> complete is LAT+1 cycles
  localparam int LG_ROB   = `LG_ROB_ENTRIES;
  localparam int LG_PRF   = `LG_PRF_ENTRIES;
  localparam int LG_HILO  = `LG_HILO_PRF_ENTRIES;

  typedef struct packed {
    logic [63:0]        y;
    logic [LG_ROB-1:0]  rob_ptr;
    logic               gpr_val;
    logic [LG_PRF-1:0]  gpr_ptr;
    logic               hilo_val;
    logic [LG_HILO-1:0] hilo_ptr;
  } mul_wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Storage array for the writeback queue: one write port, one combinational read port.
// Latency: a write is visible on the read port the cycle after it is clocked in.
// Backpressure: none here; pointer, count and credit control live in the parent.
// Ports: clk_i clock; wr_en_i/wr_ptr_i/wr_dat_i write port; rd_ptr_i/rd_dat_o read port.
module wb_fifo #(
  parameter type entry_t = logic [7:0],
  parameter int  DEPTH   = 4,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_ptr_i,
  input  entry_t        wr_dat_i,
  input  logic [AW-1:0] rd_ptr_i,
  output entry_t        rd_dat_o
);

  // Data only; validity is tracked by the parent's count, so no reset is needed.
  entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_i] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/mul_wb_queue.sv
// Writeback buffer behind the fixed-latency multiplier; issues launch credits to the scheduler.
// Latency: in_complete -> wb_valid 1 cycle; 0 cycles when MUL_WB_BYPASS_EN is defined and the queue is empty.
// Backpressure: head held stable while wb_ready_i is low; the multiplier cannot stall, so mul_ready_o throttles launches.
// Ports: clk_i, rst_ni (async, active-low); issue_go_i/mul_ready_o credit handshake; flush_i kills queued and
//   in-flight ops; in_* multiplier completion; wb_valid_o/wb_ready_i + wb_* head entry; err_overflow_o sticky.
// Optional feature macro: MUL_WB_BYPASS_EN (combinational empty-queue bypass).
module mul_wb_queue
  import mul_wb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_go_i,
  output logic               mul_ready_o,
  input  logic               flush_i,
  input  logic               in_complete_i,
  input  logic [63:0]        in_y_i,
  input  logic [LG_ROB-1:0]  in_rob_ptr_i,
  input  logic               in_gpr_val_i,
  input  logic [LG_PRF-1:0]  in_gpr_ptr_i,
  input  logic               in_hilo_val_i,
  input  logic [LG_HILO-1:0] in_hilo_ptr_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [63:0]        wb_y_o,
  output logic [LG_ROB-1:0]  wb_rob_ptr_o,
  output logic               wb_gpr_val_o,
  output logic [LG_PRF-1:0]  wb_gpr_ptr_o,
  output logic               wb_hilo_val_o,
  output logic [LG_HILO-1:0] wb_hilo_ptr_o,
  output logic               err_overflow_o
);

  localparam int CW = LG_DEPTH + 1;

  logic [LG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [LAT:0]        infl_q, infl_d;   // bit i: an op launched i+1 cycles ago is still in the multiplier
  logic [LAT:0]        kill_q, kill_d;   // same slots, marks ops launched before a flush
  logic                err_q, err_d;

  mul_wb_entry_t in_dat, head_dat, wb_dat;
  logic          live_cmp, full, byp, wb_valid, pop, q_pop, push, ovf, mul_ready;
  logic [7:0]    occ;

  assign in_dat = '{y: in_y_i, rob_ptr: in_rob_ptr_i, gpr_val: in_gpr_val_i,
                    gpr_ptr: in_gpr_ptr_i, hilo_val: in_hilo_val_i, hilo_ptr: in_hilo_ptr_i};

  wb_fifo #(.entry_t(mul_wb_entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .wr_en_i (push),
    .wr_ptr_i(wr_ptr_q),
    .wr_dat_i(in_dat),
    .rd_ptr_i(rd_ptr_q),
    .rd_dat_o(head_dat)
  );

  // A completion counts only if its op was not launched before a flush; the
  // flush cycle itself clears the queue, so nothing lands in it then.
  assign live_cmp = in_complete_i & ~kill_q[LAT] & ~flush_i;
  assign full     = (count_q == CW'(DEPTH));

`ifdef MUL_WB_BYPASS_EN
  assign byp = (count_q == '0) & live_cmp;
`else
  assign byp = 1'b0;
`endif

  assign wb_valid = ((count_q != '0) & ~flush_i) | byp;
  assign wb_dat   = byp ? in_dat : (wb_valid ? head_dat : '0);
  assign pop      = wb_valid & wb_ready_i;
  assign q_pop    = pop & ~byp;                       // a bypassed result never touched storage
  assign push     = live_cmp & ~(byp & wb_ready_i) & (~full | pop);
  assign ovf      = live_cmp & full & ~pop;

  // Credit counts every op that will still need a slot, including the one
  // completing this cycle; that makes it conservative by at most one.
  assign occ       = 8'(count_q) + 8'($countones(infl_q));
  assign mul_ready = (occ < 8'(DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | ovf;
    infl_d   = {infl_q[LAT-1:0], issue_go_i & mul_ready & ~flush_i};
    // On flush mark both the old and the advanced slot of each op in flight;
    // the extra marks sit on empty slots, so they never hit a later launch.
    kill_d   = flush_i ? (infl_q | (infl_q << 1)) : (kill_q << 1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + LG_DEPTH'(1);
      if (q_pop) rd_ptr_d = rd_ptr_q + LG_DEPTH'(1);
      case ({push, q_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      infl_q   <= '0;
      kill_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      infl_q   <= infl_d;
      kill_q   <= kill_d;
      err_q    <= err_d;
    end
  end

  // Launching without a credit is a scheduler bug; it is reported, not gated.
  a_go_needs_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                      (issue_go_i && !flush_i) |-> mul_ready);

  assign mul_ready_o    = mul_ready;
  assign wb_valid_o     = wb_valid;
  assign wb_y_o         = wb_dat.y;
  assign wb_rob_ptr_o   = wb_dat.rob_ptr;
  assign wb_gpr_val_o   = wb_dat.gpr_val;
  assign wb_gpr_ptr_o   = wb_dat.gpr_ptr;
  assign wb_hilo_val_o  = wb_dat.hilo_val;
  assign wb_hilo_ptr_o  = wb_dat.hilo_ptr;
  assign err_overflow_o = err_q;

endmodule

// File: tb/tb_mul_wb_queue.sv
// Bench for mul_wb_queue: emulates scheduler and multiplier, keeps a queue-level reference model.
module tb_mul_wb_queue;
  import mul_wb_pkg::*;

`ifdef MUL_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               issue_go_i = 1'b0, flush_i = 1'b0, in_complete_i = 1'b0, wb_ready_i = 1'b0;
  logic [63:0]        in_y_i = '0;
  logic [LG_ROB-1:0]  in_rob_ptr_i = '0;
  logic               in_gpr_val_i = 1'b0, in_hilo_val_i = 1'b0;
  logic [LG_PRF-1:0]  in_gpr_ptr_i = '0;
  logic [LG_HILO-1:0] in_hilo_ptr_i = '0;
  logic               mul_ready_o, wb_valid_o, wb_gpr_val_o, wb_hilo_val_o, err_overflow_o;
  logic [63:0]        wb_y_o;
  logic [LG_ROB-1:0]  wb_rob_ptr_o;
  logic [LG_PRF-1:0]  wb_gpr_ptr_o;
  logic [LG_HILO-1:0] wb_hilo_ptr_o;

  mul_wb_queue dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .issue_go_i(issue_go_i), .mul_ready_o(mul_ready_o),
    .flush_i(flush_i), .in_complete_i(in_complete_i), .in_y_i(in_y_i),
    .in_rob_ptr_i(in_rob_ptr_i), .in_gpr_val_i(in_gpr_val_i), .in_gpr_ptr_i(in_gpr_ptr_i),
    .in_hilo_val_i(in_hilo_val_i), .in_hilo_ptr_i(in_hilo_ptr_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_y_o(wb_y_o),
    .wb_rob_ptr_o(wb_rob_ptr_o), .wb_gpr_val_o(wb_gpr_val_o), .wb_gpr_ptr_o(wb_gpr_ptr_o),
    .wb_hilo_val_o(wb_hilo_val_o), .wb_hilo_ptr_o(wb_hilo_ptr_o), .err_overflow_o(err_overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int            due;
    bit            killed;
    mul_wb_entry_t dat;
  } pend_t;

  typedef struct {
    bit cmp; int rob; bit rdy;   // inputs
    bit vld; int erob; bit err;  // expected outputs
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int dut_go = 0;
  mul_wb_entry_t mq[$];          // entries the queue should hold, head first
  pend_t         pend[$];        // launched ops not yet completed
  bit            m_err = 1'b0;
  bit            s_vld, s_rdy, s_err;
  mul_wb_entry_t s_dat;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic mul_wb_entry_t mk(input int r);
    mul_wb_entry_t e;
    e.y        = {32'(r) * 32'h9E37_79B9, ~32'(r)};
    e.rob_ptr  = LG_ROB'(r);
    e.gpr_val  = r[0];
    e.gpr_ptr  = LG_PRF'(r + 1);
    e.hilo_val = r[1];
    e.hilo_ptr = LG_HILO'(r);
    return e;
  endfunction

  function automatic mul_wb_entry_t rnd_entry();
    mul_wb_entry_t e;
    e.y        = {$urandom, $urandom};
    e.rob_ptr  = LG_ROB'($urandom);
    e.gpr_val  = 1'($urandom);
    e.gpr_ptr  = LG_PRF'($urandom);
    e.hilo_val = 1'($urandom);
    e.hilo_ptr = LG_HILO'($urandom);
    return e;
  endfunction

  function automatic mul_wb_entry_t dut_wb();
    return '{y: wb_y_o, rob_ptr: wb_rob_ptr_o, gpr_val: wb_gpr_val_o,
             gpr_ptr: wb_gpr_ptr_o, hilo_val: wb_hilo_val_o, hilo_ptr: wb_hilo_ptr_o};
  endfunction

  task automatic drive_in(input bit c, input mul_wb_entry_t d);
    in_complete_i = c;
    in_y_i        = d.y;
    in_rob_ptr_i  = d.rob_ptr;
    in_gpr_val_i  = d.gpr_val;
    in_gpr_ptr_i  = d.gpr_ptr;
    in_hilo_val_i = d.hilo_val;
    in_hilo_ptr_i = d.hilo_ptr;
  endtask

  // One clock cycle, entered and left at a negedge. go asks to launch (taken
  // only with a credit), fcmp forces a completion not backed by a launch.
  task automatic cycle(input bit go, input bit fl, input bit rdy, input bit fcmp, input mul_wb_entry_t idat);
    bit cmp, kil, exp_rdy, exp_vld, byp, pop, push, go_eff;
    mul_wb_entry_t cdat, exp_dat;
    cmp = 1'b0; kil = 1'b0; cdat = '0;
    if (fcmp) begin
      cmp = 1'b1; cdat = idat;
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      cmp = 1'b1; kil = pend[0].killed; cdat = pend[0].dat;
    end
    exp_rdy = (mq.size() + pend.size()) < DEPTH;
    go_eff  = go & exp_rdy & !fl & !fcmp;
    issue_go_i = go_eff;
    flush_i    = fl;
    wb_ready_i = rdy;
    drive_in(cmp, cdat);
    byp     = BYP && mq.size() == 0 && cmp && !kil && !fl;
    exp_vld = !fl && (mq.size() != 0 || byp);
    exp_dat = byp ? cdat : (mq.size() != 0 ? mq[0] : '0);
    #1;
    s_vld = wb_valid_o; s_rdy = mul_ready_o; s_err = err_overflow_o; s_dat = dut_wb();
    chk("mul_ready", mul_ready_o, exp_rdy);
    chk("wb_valid", wb_valid_o, exp_vld);
    if (exp_vld) chk("wb_entry", s_dat, exp_dat);
    chk("err_overflow", err_overflow_o, m_err);
    if (go && !fl && mul_ready_o) dut_go++;
    pop = exp_vld & rdy;
    if (fl) begin
      mq.delete();
      foreach (pend[k]) pend[k].killed = 1'b1;
    end else begin
      push = cmp & !kil & !(byp & rdy);
      if (push && mq.size() == DEPTH && !pop) m_err = 1'b1;
      else begin
        if (pop && !byp) void'(mq.pop_front());
        if (push) mq.push_back(cdat);
      end
    end
    if (cmp && !fcmp) void'(pend.pop_front());
    if (go_eff) pend.push_back('{due: cyc + LAT + 1, killed: 1'b0, dat: idat});
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, rdy, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    issue_go_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0;
    drive_in(1'b0, '0);
    #1;
    chk("rst_now_wb_valid", wb_valid_o, 1'b0);
    chk("rst_now_mul_ready", mul_ready_o, 1'b1);
    chk("rst_now_err", err_overflow_o, 1'b0);
    chk("rst_now_wb_y", wb_y_o, 64'h0);
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_hold_wb_valid", wb_valid_o, 1'b0);
    chk("rst_hold_mul_ready", mul_ready_o, 1'b1);
    chk("rst_hold_wb_rob", wb_rob_ptr_o, '0);
    rst_ni = 1'b1;
    mq.delete(); pend.delete(); m_err = 1'b0;
    @(negedge clk_i);
  endtask

  vec_t tbl[15];

  initial begin
    int t0, first;
    mul_wb_entry_t d;
    // Full queue, push+pop while full across pointer wrap, then overflow and drain.
    tbl[0]  = '{1, 0, 0, BYP, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 0, 0};
    tbl[2]  = '{1, 2, 0, 1, 0, 0};
    tbl[3]  = '{1, 3, 0, 1, 0, 0};
    tbl[4]  = '{1, 4, 1, 1, 0, 0};
    tbl[5]  = '{1, 5, 1, 1, 1, 0};
    tbl[6]  = '{1, 6, 1, 1, 2, 0};
    tbl[7]  = '{1, 7, 1, 1, 3, 0};
    tbl[8]  = '{1, 9, 0, 1, 4, 0};
    tbl[9]  = '{0, 0, 0, 1, 4, 1};
    tbl[10] = '{0, 0, 1, 1, 4, 1};
    tbl[11] = '{0, 0, 1, 1, 5, 1};
    tbl[12] = '{0, 0, 1, 1, 6, 1};
    tbl[13] = '{0, 0, 1, 1, 7, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 1};

    @(negedge clk_i);
    do_reset();

    // Single op: latency and bit-exact data.
    t0 = cyc;
    d = mk(5);
    d.y = 64'h0000_0001_FFFF_FFFE;
    cycle(1'b1, 1'b0, 1'b1, 1'b0, d);
    first = -1;
    for (int i = 0; i < LAT + 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
      if (s_vld && first < 0) begin
        first = cyc - 1;
        chk("single_y", s_dat.y, 64'h0000_0001_FFFF_FFFE);
        chk("single_rob", s_dat.rob_ptr, LG_ROB'(5));
      end
    end
    chk("single_latency", first, t0 + LAT + 2 - int'(BYP));

    // Credits: scheduler tries every cycle with writeback blocked.
    do_reset();
    dut_go = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(10 + i));
    chk("credit_launches", dut_go, DEPTH);
    chk("credit_ready_low", s_rdy, 1'b0);
    idle(LAT + 2, 1'b0);
    chk("credit_still_low", s_rdy, 1'b0);
    idle(6, 1'b1);
    chk("credit_no_ovf", s_err, 1'b0);
    chk("credit_ready_back", s_rdy, 1'b1);

    // Flush with two queued and two in flight.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(20));
    cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(21));
    idle(LAT + 1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(22));
    cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(23));
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("flush_next_vld", s_vld, 1'b0);
    idle(LAT + 2, 1'b1);
    chk("flush_dropped_vld", s_vld, 1'b0);
    chk("flush_ready", s_rdy, 1'b1);

    // Table: forced completions without launches.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      issue_go_i = 1'b0; flush_i = 1'b0;
      wb_ready_i = tbl[i].rdy;
      drive_in(tbl[i].cmp, mk(tbl[i].rob));
      #1;
      chk($sformatf("tbl%0d_vld", i), wb_valid_o, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_rob", i), wb_rob_ptr_o, LG_ROB'(tbl[i].erob));
        chk($sformatf("tbl%0d_y", i), wb_y_o, mk(tbl[i].erob).y);
      end
      chk($sformatf("tbl%0d_err", i), err_overflow_o, tbl[i].err);
      @(negedge clk_i);
    end
    drive_in(1'b0, '0);
    do_reset();

    // Random traffic with flushes and a reset in the middle.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0,
            1'($urandom_range(0, 1)), 1'b0, rnd_entry());
    end
    idle(LAT + DEPTH + 4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
